// File: rtl/inter_cfg_arb_if.sv
// -----------------------------------------------------------------------------
// inter_cfg_arb_if
// Groups the two requester command ports and the internal config register bus
// used by inter_cfg_arb.
//   slave  : arbiter view (takes commands and read data, drives responses and
//            the bus strobes)
//   master : requester / register-bus side (drives commands and read data,
//            observes responses and strobes)
// Signals
//   req_x, req_x_wr, req_x_addr[15:0], req_x_wdata[31:0]   command pulse
//   busy_x, ack_x, err_x, rdata_x[31:0]                     per-port response
//   inter_cfg_wr_en, inter_cfg_rd_en, inter_cfg_addr[15:0],
//   inter_cfg_wr_data[31:0]                                 bus request
//   inter_cfg_rd_data[31:0], inter_cfg_rd_data_valid        bus read return
// -----------------------------------------------------------------------------
interface inter_cfg_arb_if;
   logic        req_a;
   logic        req_a_wr;
   logic [15:0] req_a_addr;
   logic [31:0] req_a_wdata;
   logic        busy_a;
   logic        ack_a;
   logic        err_a;
   logic [31:0] rdata_a;

   logic        req_b;
   logic        req_b_wr;
   logic [15:0] req_b_addr;
   logic [31:0] req_b_wdata;
   logic        busy_b;
   logic        ack_b;
   logic        err_b;
   logic [31:0] rdata_b;

   logic        inter_cfg_wr_en;
   logic        inter_cfg_rd_en;
   logic [15:0] inter_cfg_addr;
   logic [31:0] inter_cfg_wr_data;
   logic [31:0] inter_cfg_rd_data;
   logic        inter_cfg_rd_data_valid;

   modport slave (
      input  req_a, req_a_wr, req_a_addr, req_a_wdata,
      input  req_b, req_b_wr, req_b_addr, req_b_wdata,
      output busy_a, ack_a, err_a, rdata_a,
      output busy_b, ack_b, err_b, rdata_b,
      output inter_cfg_wr_en, inter_cfg_rd_en, inter_cfg_addr, inter_cfg_wr_data,
      input  inter_cfg_rd_data, inter_cfg_rd_data_valid
   );

   modport master (
      output req_a, req_a_wr, req_a_addr, req_a_wdata,
      output req_b, req_b_wr, req_b_addr, req_b_wdata,
      input  busy_a, ack_a, err_a, rdata_a,
      input  busy_b, ack_b, err_b, rdata_b,
      input  inter_cfg_wr_en, inter_cfg_rd_en, inter_cfg_addr, inter_cfg_wr_data,
      output inter_cfg_rd_data, inter_cfg_rd_data_valid
   );
endinterface

// File: rtl/inter_cfg_arb.sv
// -----------------------------------------------------------------------------
// inter_cfg_arb
// Shares the internal config register bus between requester A (UDP command
// path) and requester B (local/UART command path). Each port buffers one
// command; pending commands are granted round-robin, issued as a single-cycle
// wr/rd strobe, and answered with ack (+err on read timeout / rejection).
// No new grants while init_busy is high.
// Ports
//   clk_sys    in   system clock
//   rst_n      in   synchronous active-low reset
//   init_busy  in   init config loader active
//   cfg        slave modport of inter_cfg_arb_if (commands, responses, bus)
// Parameters
//   RD_TIMEOUT  cycles spent waiting for read data before an error response
//   TO_DATA     rdata returned on read timeout
// Build option
//   CFG_ARB_WR_PROTECT_EN : reject writes to 16'h0000 or above 16'h00FF
// -----------------------------------------------------------------------------
module inter_cfg_arb #(
   parameter logic [15:0] RD_TIMEOUT = 16'd255,
   parameter logic [31:0] TO_DATA    = 32'hDEAD_BEEF
) (
   input  logic           clk_sys,
   input  logic           rst_n,
   input  logic           init_busy,
   inter_cfg_arb_if.slave cfg
);

   localparam int NUM_PORTS = 2;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

   logic [NUM_PORTS-1:0]        req;
   cmd_t [NUM_PORTS-1:0]        req_cmd;
   logic [NUM_PORTS-1:0]        pend;
   cmd_t [NUM_PORTS-1:0]        cmd;
   logic [NUM_PORTS-1:0]        clr;

   state_t                      state;
   logic                        owner;
   logic                        last_owner;
   logic [15:0]                 cnt;
   logic                        wr_en;
   logic                        rd_en;
   logic [15:0]                 bus_addr;
   logic [31:0]                 bus_wdata;
   logic [NUM_PORTS-1:0]        ack;
   logic [NUM_PORTS-1:0]        err;
   logic [NUM_PORTS-1:0][31:0]  rdata;

   logic                        gnt;
   cmd_t                        gcmd;
   logic                        reject;

   assign req[0]     = cfg.req_a;
   assign req[1]     = cfg.req_b;
   assign req_cmd[0] = {cfg.req_a_wr, cfg.req_a_addr, cfg.req_a_wdata};
   assign req_cmd[1] = {cfg.req_b_wr, cfg.req_b_addr, cfg.req_b_wdata};

   // One-deep command buffer per port; a request arriving while the port is
   // busy (including its ack cycle) is dropped.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         pend <= '0;
         cmd  <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (clr[p])
               pend[p] <= 1'b0;
            else if (req[p] && !pend[p]) begin
               pend[p] <= 1'b1;
               cmd[p]  <= req_cmd[p];
            end
         end
      end
   end

   // Round-robin: on a tie the port that was not served last wins.
   always_comb begin
      gnt  = pend[1] & (~pend[0] | ~last_owner);
      gcmd = cmd[gnt];
      clr  = '0;
      if (state == RESP) clr[owner] = 1'b1;
   end

`ifdef CFG_ARB_WR_PROTECT_EN
   // Version register and anything outside the low page are read-only.
   assign reject = gcmd.wr && ((gcmd.addr == 16'h0000) || (gcmd.addr > 16'h00FF));
`else
   assign reject = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         cnt        <= '0;
         wr_en      <= 1'b0;
         rd_en      <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         ack        <= '0;
         err        <= '0;
         rdata      <= '0;
      end else begin
         wr_en <= 1'b0;
         rd_en <= 1'b0;
         ack   <= '0;
         err   <= '0;
         case (state)
            IDLE: begin
               if (!init_busy && (|pend)) begin
                  owner <= gnt;
                  if (reject) begin
                     // No bus access; answer straight away.
                     ack[gnt] <= 1'b1;
                     err[gnt] <= 1'b1;
                     state    <= RESP;
                  end else begin
                     bus_addr  <= gcmd.addr;
                     bus_wdata <= gcmd.wdata;
                     wr_en     <= gcmd.wr;
                     rd_en     <= ~gcmd.wr;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (cmd[owner].wr) begin
                  ack[owner] <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt   <= '0;
                  state <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (cfg.inter_cfg_rd_data_valid) begin
                  rdata[owner] <= cfg.inter_cfg_rd_data;
                  ack[owner]   <= 1'b1;
                  state        <= RESP;
               end else if (cnt == RD_TIMEOUT - 16'd1) begin
                  rdata[owner] <= TO_DATA;
                  ack[owner]   <= 1'b1;
                  err[owner]   <= 1'b1;
                  state        <= RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               last_owner <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg.busy_a            = pend[0];
   assign cfg.busy_b            = pend[1];
   assign cfg.ack_a             = ack[0];
   assign cfg.ack_b             = ack[1];
   assign cfg.err_a             = err[0];
   assign cfg.err_b             = err[1];
   assign cfg.rdata_a           = rdata[0];
   assign cfg.rdata_b           = rdata[1];
   assign cfg.inter_cfg_wr_en   = wr_en;
   assign cfg.inter_cfg_rd_en   = rd_en;
   assign cfg.inter_cfg_addr    = bus_addr;
   assign cfg.inter_cfg_wr_data = bus_wdata;

endmodule

// File: tb/tb_inter_cfg_arb.sv
// -----------------------------------------------------------------------------
// tb_inter_cfg_arb
// Directed scenarios with literal expectations, then randomized traffic. A
// transaction-timeline model (grant time, strobe time, ack time) predicts every
// output each cycle; a register-bus responder answers reads with random delay,
// occasionally never, and drives stray rd_data_valid pulses when idle.
// -----------------------------------------------------------------------------
module tb_inter_cfg_arb;

   localparam logic [15:0] RD_TIMEOUT = 16'd255;
   localparam logic [31:0] TO_DATA    = 32'hDEAD_BEEF;

   logic clk_sys   = 1'b0;
   logic rst_n     = 1'b0;
   logic init_busy = 1'b0;

   inter_cfg_arb_if cfg_if ();

   inter_cfg_arb #(.RD_TIMEOUT(RD_TIMEOUT), .TO_DATA(TO_DATA)) dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .init_busy (init_busy),
      .cfg       (cfg_if)
   );

   always #5 clk_sys = ~clk_sys;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- model ----------------
   int          e = 0;
   bit          m_ok = 0;
   bit [1:0]    m_pend = '0;
   bit          m_cwr [2];
   logic [15:0] m_caddr [2];
   logic [31:0] m_cdata [2];
   bit          act = 0, acked = 0;
   int          owner = 0, last_owner = 1;
   int          strobe = 0, ack_cyc = 0, free_from = 0;
   bit          x_wr_en = 0, x_rd_en = 0;
   bit [1:0]    x_ack = '0, x_err = '0;
   logic [15:0] x_addr = '0;
   logic [31:0] x_wdata = '0;
   logic [31:0] x_rdata [2] = '{32'h0, 32'h0};

   function automatic bit is_protected(input bit wr, input logic [15:0] a);
`ifdef CFG_ARB_WR_PROTECT_EN
      return wr && ((a == 16'h0000) || (a > 16'h00FF));
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk_sys) begin : model
      bit [1:0] pb;
      e++;
      if (!rst_n) begin
         m_pend = '0; act = 0; acked = 0; last_owner = 1; free_from = e + 1;
         x_wr_en = 0; x_rd_en = 0; x_ack = '0; x_err = '0;
         x_addr = '0; x_wdata = '0; x_rdata[0] = '0; x_rdata[1] = '0;
         m_ok = 1;
      end else begin
         pb = m_pend;
         x_wr_en = 0; x_rd_en = 0; x_ack = '0; x_err = '0;
         if (act && acked && e == ack_cyc + 1) begin
            m_pend[owner] = 0; last_owner = owner; act = 0; free_from = e + 1;
         end else if (act && !acked) begin
            if (m_cwr[owner]) begin
               if (e == strobe + 1) begin x_ack[owner] = 1; acked = 1; ack_cyc = e; end
            end else if (cfg_if.inter_cfg_rd_data_valid && (e - 1 >= strobe + 1)) begin
               x_rdata[owner] = cfg_if.inter_cfg_rd_data;
               x_ack[owner] = 1; acked = 1; ack_cyc = e;
            end else if (e - 1 == strobe + int'(RD_TIMEOUT)) begin
               x_rdata[owner] = TO_DATA;
               x_ack[owner] = 1; x_err[owner] = 1; acked = 1; ack_cyc = e;
            end
         end else if (!act && e >= free_from && !init_busy && pb != 2'b00) begin
            owner = (pb == 2'b11) ? 1 - last_owner : (pb[0] ? 0 : 1);
            act = 1; acked = 0; strobe = e;
            if (is_protected(m_cwr[owner], m_caddr[owner])) begin
               x_ack[owner] = 1; x_err[owner] = 1; acked = 1; ack_cyc = e;
            end else begin
               x_addr = m_caddr[owner]; x_wdata = m_cdata[owner];
               if (m_cwr[owner]) x_wr_en = 1; else x_rd_en = 1;
            end
         end
         if (cfg_if.req_a && !pb[0]) begin
            m_pend[0] = 1; m_cwr[0] = cfg_if.req_a_wr;
            m_caddr[0] = cfg_if.req_a_addr; m_cdata[0] = cfg_if.req_a_wdata;
         end
         if (cfg_if.req_b && !pb[1]) begin
            m_pend[1] = 1; m_cwr[1] = cfg_if.req_b_wr;
            m_caddr[1] = cfg_if.req_b_addr; m_cdata[1] = cfg_if.req_b_wdata;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk1(input string n, input logic a, input logic x);
      vectors++;
      if (a !== x) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %b expected %b", n, e, a, x);
      end
   endtask

   task automatic chk16(input string n, input logic [15:0] a, input logic [15:0] x);
      vectors++;
      if (a !== x) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %h expected %h", n, e, a, x);
      end
   endtask

   task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] x);
      vectors++;
      if (a !== x) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %h expected %h", n, e, a, x);
      end
   endtask

   task automatic compare_all();
      chk1 ("busy_a",  cfg_if.busy_a,            m_pend[0]);
      chk1 ("busy_b",  cfg_if.busy_b,            m_pend[1]);
      chk1 ("ack_a",   cfg_if.ack_a,             x_ack[0]);
      chk1 ("ack_b",   cfg_if.ack_b,             x_ack[1]);
      chk1 ("err_a",   cfg_if.err_a,             x_err[0]);
      chk1 ("err_b",   cfg_if.err_b,             x_err[1]);
      chk32("rdata_a", cfg_if.rdata_a,           x_rdata[0]);
      chk32("rdata_b", cfg_if.rdata_b,           x_rdata[1]);
      chk1 ("wr_en",   cfg_if.inter_cfg_wr_en,   x_wr_en);
      chk1 ("rd_en",   cfg_if.inter_cfg_rd_en,   x_rd_en);
      chk16("addr",    cfg_if.inter_cfg_addr,    x_addr);
      chk32("wr_data", cfg_if.inter_cfg_wr_data, x_wdata);
   endtask

   // ---------------- stimulus / responder ----------------
   int          rsp_wait  = 0;
   bit          rsp_never = 0;
   int          rsp_mode  = 0;   // 0 random, 1 delay 1 fixed data, 2 never
   logic [31:0] rsp_fixed = '0;
   logic [31:0] rsp_val   = '0;
   bit          spur_en   = 0;

   task automatic tick();
      @(negedge clk_sys);
      if (m_ok) compare_all();
      cfg_if.req_a = 1'b0;
      cfg_if.req_b = 1'b0;
      cfg_if.inter_cfg_rd_data_valid = 1'b0;
      cfg_if.inter_cfg_rd_data = $urandom;
      if (rsp_wait > 0) begin
         rsp_wait--;
         if (rsp_wait == 0 && !rsp_never) begin
            cfg_if.inter_cfg_rd_data_valid = 1'b1;
            cfg_if.inter_cfg_rd_data = rsp_val;
         end
      end else if (cfg_if.inter_cfg_rd_en) begin
         rsp_val = $urandom; rsp_never = 0;
         case (rsp_mode)
            1: begin rsp_wait = 1; rsp_val = rsp_fixed; end
            2: rsp_never = 1;
            default: if ($urandom_range(0, 15) == 0) rsp_never = 1;
                     else rsp_wait = $urandom_range(1, 4);
         endcase
         if (rsp_never) rsp_wait = int'(RD_TIMEOUT) + 3;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
         cfg_if.inter_cfg_rd_data_valid = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic issue(input int p, input bit wr, input logic [15:0] a, input logic [31:0] d);
      if (p == 0) begin
         cfg_if.req_a = 1'b1; cfg_if.req_a_wr = wr; cfg_if.req_a_addr = a; cfg_if.req_a_wdata = d;
      end else begin
         cfg_if.req_b = 1'b1; cfg_if.req_b_wr = wr; cfg_if.req_b_addr = a; cfg_if.req_b_wdata = d;
      end
   endtask

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(0, 4))
         0:       return 16'h0000;
         1:       return 16'h00FF;
         2:       return 16'h0100;
         3:       return 16'($urandom_range(0, 255));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t;
      bit seen;
      cfg_if.req_a = 0; cfg_if.req_a_wr = 0; cfg_if.req_a_addr = '0; cfg_if.req_a_wdata = '0;
      cfg_if.req_b = 0; cfg_if.req_b_wr = 0; cfg_if.req_b_addr = '0; cfg_if.req_b_wdata = '0;
      cfg_if.inter_cfg_rd_data = '0; cfg_if.inter_cfg_rd_data_valid = 0;

      // reset state
      idle(3);
      chk1 ("rst_busy_a", cfg_if.busy_a, 1'b0);
      chk1 ("rst_ack_b",  cfg_if.ack_b,  1'b0);
      chk1 ("rst_wr_en",  cfg_if.inter_cfg_wr_en, 1'b0);
      chk16("rst_addr",   cfg_if.inter_cfg_addr, 16'h0000);
      chk32("rst_rdata_b", cfg_if.rdata_b, 32'h0);
      rst_n = 1'b1;
      idle(3);

      // 1: write from A
      issue(0, 1, 16'h0013, 32'h0000_1000);
      tick(); chk1("t1_busy_c1", cfg_if.busy_a, 1'b1);
      tick(); chk1("t1_wr_en_c2", cfg_if.inter_cfg_wr_en, 1'b1);
              chk16("t1_addr_c2", cfg_if.inter_cfg_addr, 16'h0013);
              chk32("t1_data_c2", cfg_if.inter_cfg_wr_data, 32'h0000_1000);
      tick(); chk1("t1_ack_c3", cfg_if.ack_a, 1'b1);
              chk1("t1_err_c3", cfg_if.err_a, 1'b0);
              chk1("t1_wr_en_c3", cfg_if.inter_cfg_wr_en, 1'b0);
      tick(); chk1("t1_busy_c4", cfg_if.busy_a, 1'b0);
      idle(3);

      // 2: read from B, data one cycle after strobe
      rsp_mode = 1; rsp_fixed = 32'h5555_AAAA;
      issue(1, 0, 16'h0001, 32'h0);
      tick();
      tick(); chk1("t2_rd_en_c2", cfg_if.inter_cfg_rd_en, 1'b1);
              chk16("t2_addr_c2", cfg_if.inter_cfg_addr, 16'h0001);
      tick(); chk1("t2_ack_c3", cfg_if.ack_b, 1'b0);
      tick(); chk1("t2_ack_c4", cfg_if.ack_b, 1'b1);
              chk32("t2_rdata_c4", cfg_if.rdata_b, 32'h5555_AAAA);
      idle(4);

      // 3: simultaneous writes, A then B, and A first again
      issue(0, 1, 16'h0020, 32'h1); issue(1, 1, 16'h0030, 32'h2);
      tick(); tick();
      chk16("t3_first_addr", cfg_if.inter_cfg_addr, 16'h0020);
      tick(); tick(); tick();
      chk1 ("t3_second_wr_en", cfg_if.inter_cfg_wr_en, 1'b1);
      chk16("t3_second_addr", cfg_if.inter_cfg_addr, 16'h0030);
      chk32("t3_second_data", cfg_if.inter_cfg_wr_data, 32'h2);
      idle(4);
      issue(0, 1, 16'h0021, 32'h3); issue(1, 1, 16'h0031, 32'h4);
      tick(); tick();
      chk16("t3_repeat_first", cfg_if.inter_cfg_addr, 16'h0021);
      idle(8);

      // 4: read timeout
      rsp_mode = 2;
      issue(1, 0, 16'h0002, 32'h0);
      t = 0; seen = 0;
      while (!seen && t < int'(RD_TIMEOUT) + 20) begin
         tick(); t++;
         if (cfg_if.ack_b) seen = 1;
      end
      chk1("t4_ack_seen", cfg_if.ack_b, 1'b1);
      vectors++;
      if (t != int'(RD_TIMEOUT) + 3) begin
         miscompares++;
         $display("FAIL t4_ack_cycle: got %0d expected %0d", t, int'(RD_TIMEOUT) + 3);
      end
      chk1 ("t4_err", cfg_if.err_b, 1'b1);
      chk32("t4_rdata", cfg_if.rdata_b, 32'hDEAD_BEEF);
      idle(4);
      rsp_mode = 0;

      // 5: init_busy holds off the grant; second req dropped
      init_busy = 1'b1;
      issue(0, 1, 16'h0044, 32'hA5A5_0001);
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk1("t5_no_strobe", cfg_if.inter_cfg_wr_en, 1'b0);
         if (i == 5) issue(0, 1, 16'h0055, 32'hA5A5_0002);
      end
      init_busy = 1'b0;
      tick(); chk1("t5_wr_en", cfg_if.inter_cfg_wr_en, 1'b1);
              chk16("t5_addr", cfg_if.inter_cfg_addr, 16'h0044);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("t5_dropped_busy", cfg_if.busy_a, 1'b0);
      end

`ifdef CFG_ARB_WR_PROTECT_EN
      // 6: protected write rejected, normal write forwarded
      issue(0, 1, 16'h0000, 32'h1234);
      tick(); tick();
      chk1("t6_ack_c2", cfg_if.ack_a, 1'b1);
      chk1("t6_err_c2", cfg_if.err_a, 1'b1);
      chk1("t6_no_wr_en", cfg_if.inter_cfg_wr_en, 1'b0);
      tick(); chk1("t6_busy_c3", cfg_if.busy_a, 1'b0);
      idle(3);
      issue(0, 1, 16'h0010, 32'h5678);
      tick(); tick();
      chk1("t6_ok_wr_en", cfg_if.inter_cfg_wr_en, 1'b1);
      tick();
      chk1("t6_ok_ack", cfg_if.ack_a, 1'b1);
      chk1("t6_ok_err", cfg_if.err_a, 1'b0);
      idle(3);
`endif

      // randomized traffic, with one reset in the middle
      spur_en = 1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i == 1500) rst_n = 1'b0;
         if (i == 1502) rst_n = 1'b1;
         if ($urandom_range(0, 39) == 0) init_busy = ~init_busy;
         if ($urandom_range(0, 3) == 0) issue(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         if ($urandom_range(0, 3) == 0) issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      init_busy = 1'b0;
      spur_en = 0;
      idle(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
